ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 5000, setting the Clk cycles the PS/2 clock is held low before the request (100 us at 50 MHz).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 750000, setting the maximum Clk cycles allowed between device clock falling edges (15 ms at 50 MHz).
REQ-003 Port Clk  in  1  system clock; all logic rises on posedge Clk.
REQ-004 Port Reset  in  1  reset, asynchronous, active-low.
REQ-005 Port ClkKB  in  1  raw PS/2 clock line level, asynchronous.
REQ-006 Port DataKB  in  1  raw PS/2 data line level, asynchronous.
REQ-007 Port ClkKB_oe  out  1  1 = pull PS/2 clock low (open-drain), 0 = release.
REQ-008 Port DataKB_oe  out  1  1 = pull PS/2 data low (open-drain), 0 = release.
REQ-009 Port Start  in  1  one-cycle request to send TxData; sampled only when Busy=0.
REQ-010 Port TxData  in  8  command byte, captured on the accepted Start cycle.
REQ-011 Port Busy  out  1  high from the cycle after an accepted Start until return to IDLE.
REQ-012 Port Done  out  1  one-cycle pulse: device acknowledged (ACK bit low).
REQ-013 Port Error  out  1  one-cycle pulse: missing ACK or timeout.

Function
REQ-014 ClkKB and DataKB SHALL pass through 2-flop synchronizers; a falling-edge event (fall_evt) SHALL be a one-cycle pulse raised when synchronized ClkKB, previously high, reads low on two consecutive samples.
REQ-015 States SHALL be IDLE, INHIBIT, REQ, SEND, WAIT_RELEASE.
REQ-016 IDLE: both oe=0; Start=1 latches TxData and parity = XNOR-reduce(TxData) (odd parity) and enters INHIBIT.
REQ-017 INHIBIT: ClkKB_oe=1, DataKB_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-018 REQ: ClkKB_oe=1, DataKB_oe=1 for exactly 1 cycle, then SEND with bit index 0.
REQ-019 SEND: ClkKB_oe=0; DataKB_oe=1 (start bit) until the first fall_evt.
REQ-020 On fall_evt n (n=1..10) DataKB_oe SHALL update in the same cycle to the inverse of: TxData[n-1] for n=1..8, parity for n=9, 1 (stop, released) for n=10.
REQ-021 On fall_evt 11, synchronized DataKB=0 SHALL pulse Done, else Error; both then go to WAIT_RELEASE.
REQ-022 A timeout counter SHALL clear on entering SEND and on each fall_evt; reaching TIMEOUT_CYCLES in SEND SHALL pulse Error, force both oe=0, and go to WAIT_RELEASE.
REQ-023 WAIT_RELEASE: both oe=0; enter IDLE when synchronized ClkKB and DataKB are both 1.
REQ-024 Start while Busy=1 SHALL be ignored with no effect on the transfer in progress.
REQ-025 Done and Error SHALL be mutually exclusive, and exactly one SHALL pulse per accepted Start.
REQ-026 Glitches on ClkKB of 1 synchronized sample SHALL NOT produce fall_evt.

Reset
REQ-027 Reset=0 SHALL immediately force IDLE, ClkKB_oe=0, DataKB_oe=0, Busy=0, Done=0, Error=0, and clear all counters, including mid-transfer.
REQ-028 After Reset deassertion the first Start SHALL be accepted normally.

Structure
REQ-029 State encoding and default INHIBIT_CYCLES/TIMEOUT_CYCLES SHALL reside in shared package ps2_pkg, shared with the receive side.
REQ-030 Synchronizer plus falling-edge filter SHALL be sub-module ps2_edge_filter, reusable by the receiver.

Verification
REQ-031 TxData=8'hED with a device model clocking at 12 kHz and ACK low -> line carries 0,1,0,1,1,0,1,1,1, parity 1, stop 1; one Done pulse; Busy low after lines idle.
REQ-032 TxData=8'h01 -> parity bit 0; TxData=8'hFF -> parity bit 1; TxData=8'h00 -> parity bit 1.
REQ-033 Device leaves data high at ACK -> one Error pulse, no Done.
REQ-034 Device stops clocking after bit 4 -> Error exactly TIMEOUT_CYCLES after last fall_evt, both oe=0.
REQ-035 Reset=0 asserted during bit 3 -> both oe=0 that cycle; next Start of 8'hF4 completes with Done.
REQ-036 Start pulsed during SEND plus a 1-sample ClkKB glitch -> no restart, no extra bit, transfer completes unchanged.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 state encoding, default timings and parity helper shared by host tx and rx
package ps2_pkg;

    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_TIMEOUT_CYCLES = 750000;

    // Frame slot of the stop bit: slots are start, 8 data, parity, stop.
    localparam logic [3:0] LAST_BIT = 4'd10;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        WAIT_RELEASE
    } ps2State_t;

    function automatic logic oddParity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// rtl/ps2_edge_filter.sv - PS/2 line synchronizers and glitch-filtered clock falling-edge detector
module ps2_edge_filter (
    input  logic Clk,
    input  logic Reset,
    input  logic ClkKB,
    input  logic DataKB,
    output logic ClkSync,
    output logic DataSync,
    output logic FallEvt
);

    logic [1:0] clkMeta;
    logic [1:0] dataMeta;
    logic [1:0] clkHist;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            clkMeta  <= 2'b11;
            dataMeta <= 2'b11;
            clkHist  <= 2'b11;
        end else begin
            clkMeta  <= {clkMeta[0], ClkKB};
            dataMeta <= {dataMeta[0], DataKB};
            clkHist  <= {clkHist[0], clkMeta[1]};
        end
    end

    assign ClkSync  = clkMeta[1];
    assign DataSync = dataMeta[1];

    // High, then low on two consecutive samples: a single low sample never fires.
    assign FallEvt = clkHist[1] & ~clkHist[0] & ~clkMeta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter with ACK check and timeout
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ClkKB,
    input  logic       DataKB,
    output logic       ClkKB_oe,
    output logic       DataKB_oe,
    input  logic       Start,
    input  logic [7:0] TxData,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2State_t        state;
    ps2State_t        nextState;
    logic [7:0]       txByte;
    logic             parity;
    logic [3:0]       bitIdx;
    logic [3:0]       nextIdx;
    logic [CNT_W-1:0] cycCnt;
    logic [10:0]      frame;
    logic             clkSync;
    logic             dataSync;
    logic             fallEvt;

    ps2_edge_filter uEdge (
        .Clk      (Clk),
        .Reset    (Reset),
        .ClkKB    (ClkKB),
        .DataKB   (DataKB),
        .ClkSync  (clkSync),
        .DataSync (dataSync),
        .FallEvt  (fallEvt)
    );

    assign frame   = {1'b1, parity, txByte, 1'b0};
    assign nextIdx = bitIdx + 4'd1;
    assign Busy    = (state != IDLE);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        ClkKB_oe  = 1'b0;
        DataKB_oe = 1'b0;
        Done      = 1'b0;
        Error     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) nextState = INHIBIT;
            end
            INHIBIT: begin
                ClkKB_oe = 1'b1;
                if (cycCnt == INHIBIT_LAST) nextState = REQ;
            end
            REQ: begin
                ClkKB_oe  = 1'b1;
                DataKB_oe = 1'b1;
                nextState = SEND;
            end
            SEND: begin
                // The line moves to the next slot in the very cycle the fall is seen.
                if (fallEvt) begin
                    if (bitIdx == LAST_BIT) begin
                        Done      = ~dataSync;
                        Error     = dataSync;
                        nextState = WAIT_RELEASE;
                    end else begin
                        DataKB_oe = ~frame[nextIdx];
                    end
                end else if (cycCnt == TIMEOUT_LAST) begin
                    Error     = 1'b1;
                    nextState = WAIT_RELEASE;
                end else begin
                    DataKB_oe = ~frame[bitIdx];
                end
            end
            WAIT_RELEASE: begin
                if (clkSync && dataSync) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            txByte <= 8'h00;
            parity <= 1'b0;
            bitIdx <= 4'd0;
            cycCnt <= '0;
        end else begin
            if (state == IDLE && Start) begin
                txByte <= TxData;
                parity <= oddParity(TxData);
            end
            if (state == REQ) begin
                bitIdx <= 4'd0;
            end else if (state == SEND && fallEvt) begin
                bitIdx <= nextIdx;
            end
            // Our own inhibit pull also produces a fall, so only SEND falls restart the count.
            if (nextState != state || state == IDLE || state == WAIT_RELEASE ||
                (state == SEND && fallEvt)) begin
                cycCnt <= '0;
            end else begin
                cycCnt <= cycCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

    localparam int INH      = 20;
    localparam int TMO      = 300;
    localparam int HALF     = 12;
    localparam int SYNC_LAT = 3;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       devClk;
    logic       devData;
    logic       ClkKB;
    logic       DataKB;
    logic       ClkKB_oe;
    logic       DataKB_oe;
    logic       Start;
    logic [7:0] TxData;
    logic       Busy;
    logic       Done;
    logic       Error;

    int total   = 0;
    int bad     = 0;
    int doneCnt = 0;
    int errCnt  = 0;

    assign ClkKB  = devClk & ~ClkKB_oe;
    assign DataKB = devData & ~DataKB_oe;

    always #5 Clk = ~Clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ClkKB     (ClkKB),
        .DataKB    (DataKB),
        .ClkKB_oe  (ClkKB_oe),
        .DataKB_oe (DataKB_oe),
        .Start     (Start),
        .TxData    (TxData),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Line frame as the device should see it: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] modelFrame(input logic [7:0] d);
        int          ones;
        logic [10:0] f;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = d[i];
            if (d[i]) ones++;
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    always @(negedge Clk) begin
        if (Reset) begin
            if (Done) doneCnt++;
            if (Error) errCnt++;
            if (!Busy) check("idle_oe", 32'({ClkKB_oe, DataKB_oe}), 32'd0);
            if (Done || Error) begin
                check("pulse_excl", 32'(Done & Error), 32'd0);
                check("pulse_busy", 32'(Busy), 32'd1);
            end
        end
    end

    task automatic runTx(input logic [7:0] d, input bit ack, input int falls, input int resetAt,
                         input bit disturb, output logic [10:0] rx);
        logic [10:0] fr;
        int          c;
        int          d0;
        int          e0;
        int          elapsed;
        int          expDone;
        int          expErr;
        bit          wasReset;
        fr       = modelFrame(d);
        rx       = '0;
        wasReset = 0;
        elapsed  = 0;
        d0       = doneCnt;
        e0       = errCnt;
        expDone  = (falls >= 11 && ack && resetAt == 0) ? 1 : 0;
        expErr   = (resetAt == 0 && expDone == 0) ? 1 : 0;

        Start = 1'b1; TxData = d;
        tick(1);
        Start = 1'b0; TxData = ~d;
        check("busy_after_start", 32'(Busy), 32'd1);
        c = 0;
        while (ClkKB_oe && !DataKB_oe && c < 10 * INH) begin
            c++;
            tick(1);
        end
        check("inhibit_len", 32'(c), 32'(INH));
        check("req_oe", 32'({ClkKB_oe, DataKB_oe}), 32'd3);
        tick(1);
        check("start_bit_oe", 32'({ClkKB_oe, DataKB_oe}), 32'd1);
        tick(HALF);
        rx[0] = DataKB;

        for (int n = 1; n <= 11; n++) begin
            if (n > falls) break;
            devClk = 1'b0;
            tick(SYNC_LAT - 1);
            check("oe_before_evt", 32'(DataKB_oe), 32'(!fr[n-1]));
            tick(1);
            if (n <= 10) begin
                check("oe_at_evt", 32'(DataKB_oe), 32'(!fr[n]));
                check("busy_in_send", 32'(Busy), 32'd1);
            end else begin
                check("done_at_ack", 32'(Done), 32'(ack));
                check("error_at_ack", 32'(Error), 32'(!ack));
                check("oe_at_ack", 32'({ClkKB_oe, DataKB_oe}), 32'd0);
            end
            if (n == resetAt) begin
                #2 Reset = 1'b0;
                #1;
                check("reset_oe", 32'({ClkKB_oe, DataKB_oe}), 32'd0);
                check("reset_busy", 32'(Busy), 32'd0);
                check("reset_pulses", 32'({Done, Error}), 32'd0);
                wasReset = 1;
                break;
            end
            tick(HALF - SYNC_LAT);
            devClk = 1'b1;
            if (n <= 10) rx[n] = DataKB;
            if (n == 10 && ack) devData = 1'b0;
            if (n == 11) devData = 1'b1;
            if (disturb && n == 5) begin
                tick(4);
                devClk = 1'b0; Start = 1'b1; TxData = 8'h55;
                tick(1);
                devClk = 1'b1; Start = 1'b0;
                tick(HALF - 5);
            end else begin
                tick(HALF);
            end
            elapsed = 2 * HALF - SYNC_LAT;
        end

        if (wasReset) begin
            devClk = 1'b1; devData = 1'b1;
            tick(2);
            Reset = 1'b1;
            tick(2);
        end else if (falls < 11) begin
            c = elapsed;
            while (!Error && c < TMO + 50) begin
                tick(1);
                c++;
            end
            check("timeout_at", 32'(c), 32'(TMO));
            check("timeout_oe", 32'({ClkKB_oe, DataKB_oe}), 32'd0);
        end
        c = 0;
        while (Busy && c < 100) begin
            tick(1);
            c++;
        end
        check("busy_released", 32'(Busy), 32'd0);
        tick(2);
        check("done_count", 32'(doneCnt - d0), 32'(expDone));
        check("error_count", 32'(errCnt - e0), 32'(expErr));
    endtask

    initial begin
        logic [10:0] rx;
        Reset = 1'b0; devClk = 1'b1; devData = 1'b1; Start = 1'b0; TxData = 8'h00;
        tick(3);
        check("rst_outputs", 32'({ClkKB_oe, DataKB_oe, Busy, Done, Error}), 32'd0);
        Reset = 1'b1;
        tick(3);

        runTx(8'hED, 1'b1, 11, 0, 1'b0, rx);
        check("frame_ed_model", 32'(rx), 32'(modelFrame(8'hED)));
        check("frame_ed_literal", 32'(rx), 32'(11'b111_1101_1010));

        runTx(8'h01, 1'b1, 11, 0, 1'b0, rx);
        check("parity_01", 32'(rx[9]), 32'd0);
        runTx(8'hFF, 1'b1, 11, 0, 1'b0, rx);
        check("parity_ff", 32'(rx[9]), 32'd1);
        runTx(8'h00, 1'b1, 11, 0, 1'b0, rx);
        check("parity_00", 32'(rx[9]), 32'd1);
        check("frame_00_model", 32'(rx), 32'(modelFrame(8'h00)));

        runTx(8'hA5, 1'b0, 11, 0, 1'b0, rx);
        check("frame_a5_model", 32'(rx), 32'(modelFrame(8'hA5)));

        runTx(8'h3C, 1'b1, 4, 0, 1'b0, rx);

        runTx(8'h00, 1'b1, 11, 3, 1'b0, rx);
        runTx(8'hF4, 1'b1, 11, 0, 1'b0, rx);
        check("frame_f4_model", 32'(rx), 32'(modelFrame(8'hF4)));

        runTx(8'h5A, 1'b1, 11, 0, 1'b1, rx);
        check("frame_5a_model", 32'(rx), 32'(modelFrame(8'h5A)));
        tick(30);
        check("no_restart", 32'({ClkKB_oe, Busy}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
